// File: rtl/uart_tx_peripheral_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_peripheral_pkg : memory map, FSM encoding and status-word layout    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package uart_tx_peripheral_pkg;

   localparam logic [31:0] UART_DATA_ADDR   = 32'h1000_0000;
   localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;

   // Read-data source select used by the memory controller's return mux.
   localparam logic [1:0] DSRC_RAM  = 2'd0;
   localparam logic [1:0] DSRC_ROM  = 2'd1;
   localparam logic [1:0] DSRC_UART = 2'd2;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   localparam int STAT_FULL_BIT     = 0;
   localparam int STAT_EMPTY_BIT    = 1;
   localparam int STAT_BUSY_BIT     = 2;
   localparam int STAT_OVERFLOW_BIT = 3;

   function automatic logic [7:0] uart_status_word(input logic full, input logic empty,
                                                   input logic busy, input logic ovf);
      logic [7:0] w;
      w = 8'h00;
      w[STAT_FULL_BIT]     = full;
      w[STAT_EMPTY_BIT]    = empty;
      w[STAT_BUSY_BIT]     = busy;
      w[STAT_OVERFLOW_BIT] = ovf;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_peripheral_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo : register-array FIFO with occupancy count, guarded push/pop      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 8,
   parameter int COUNT_W = $clog2(DEPTH) + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [WIDTH-1:0]   data_i,
   output logic [WIDTH-1:0]   data_o,
   output logic               full_o,
   output logic               empty_o,
   output logic [COUNT_W-1:0] count_o
);
   localparam int c_ptr_w = $clog2(DEPTH);

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [c_ptr_w-1:0] wr_ptr_q;
   logic [c_ptr_w-1:0] rd_ptr_q;
   logic [COUNT_W-1:0] count_q;
   logic               w_push_ok;
   logic               w_pop_ok;

   assign w_push_ok = push_i && !full_o;
   assign w_pop_ok  = pop_i && !empty_o;

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (w_push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push_ok) wr_ptr_q <= wr_ptr_q + c_ptr_w'(1);
         if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   count_q <= count_q + COUNT_W'(1);
            2'b01:   count_q <= count_q - COUNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == COUNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_peripheral.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_peripheral : memory-mapped 8N1 transmitter with transmit FIFO       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_tx_peripheral
   import uart_tx_peripheral_pkg::*;
#(
   parameter int CLKS_PER_BIT = 234,
   parameter int FIFO_DEPTH   = 8,
   parameter int COUNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   write_enable,
   input  logic [7:0]             write_data,
   input  logic                   clear_overflow,
   output logic                   tx,
   output logic                   tx_busy,
   output logic                   fifo_full,
   output logic                   fifo_empty,
   output logic [COUNT_WIDTH-1:0] fifo_count,
   output logic                   overflow
);
   localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   uart_state_e         state_q;
   logic [c_baud_w-1:0] baud_q;
   logic [2:0]          bit_idx_q;
   logic [7:0]          shift_q;
   logic                tx_q;
   logic                overflow_q;
   logic                overflow_d;

   logic                w_baud_end;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [7:0]          w_head;

   sync_fifo #(
      .WIDTH   (8),
      .DEPTH   (FIFO_DEPTH),
      .COUNT_W (COUNT_WIDTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (write_enable),
      .pop_i   (w_pop),
      .data_i  (write_data),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (fifo_count)
   );

   assign w_baud_end = (baud_q == c_baud_w'(CLKS_PER_BIT - 1));
   // Pops line up exactly with the FSM's IDLE->START and STOP->START loads below.
   assign w_pop = !w_empty &&
                  ((state_q == UART_IDLE) || ((state_q == UART_STOP) && w_baud_end));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= UART_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            UART_IDLE: begin
               tx_q   <= 1'b1;
               baud_q <= '0;
               if (!w_empty) begin
                  shift_q <= w_head;
                  state_q <= UART_START;
                  tx_q    <= 1'b0;
               end
            end
            UART_START: begin
               if (w_baud_end) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  state_q   <= UART_DATA;
                  tx_q      <= shift_q[0];
               end else begin
                  baud_q <= baud_q + c_baud_w'(1);
               end
            end
            UART_DATA: begin
               if (w_baud_end) begin
                  baud_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= UART_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     shift_q   <= shift_q >> 1;
                     tx_q      <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + c_baud_w'(1);
               end
            end
            UART_STOP: begin
               if (w_baud_end) begin
                  baud_q <= '0;
                  if (!w_empty) begin
                     shift_q <= w_head;
                     state_q <= UART_START;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= UART_IDLE;
                  end
               end else begin
                  baud_q <= baud_q + c_baud_w'(1);
               end
            end
            default: begin
               state_q <= UART_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   // A dropped write outranks a simultaneous clear so no overflow goes unreported.
   always_comb begin
      overflow_d = overflow_q;
      if (clear_overflow)         overflow_d = 1'b0;
      if (write_enable && w_full) overflow_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;
   end

   assign tx         = tx_q;
   assign tx_busy    = (state_q != UART_IDLE);
   assign fifo_full  = w_full;
   assign fifo_empty = w_empty;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_peripheral.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_peripheral : directed vectors and corner sequences, CPB=4 D=4    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_tx_peripheral;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          write_enable = 1'b0;
   logic [7:0]    write_data = 8'h00;
   logic          clear_overflow = 1'b0;
   logic          tx;
   logic          tx_busy;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   uart_tx_peripheral #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .COUNT_WIDTH  (CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .write_enable   (write_enable),
      .write_data     (write_data),
      .clear_overflow (clear_overflow),
      .tx             (tx),
      .tx_busy        (tx_busy),
      .fifo_full      (fifo_full),
      .fifo_empty     (fifo_empty),
      .fifo_count     (fifo_count),
      .overflow       (overflow)
   );

   always #5 clock = ~clock;

   // Frames are written in transmission order: bit 9 = start, bits 8..1 = data LSB first, bit 0 = stop.
   typedef struct {
      int          nwr;
      logic [47:0] bytes;
      int          nframes;
      logic [59:0] frames;
      int          chk_k;
      logic [7:0]  exp_cnt;
      logic        exp_full;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mkv(input int nwr, input logic [47:0] b, input int nf,
                                input logic [59:0] f, input int k, input logic [7:0] cnt,
                                input logic full, input logic ovf);
      vec_t v;
      v.nwr = nwr; v.bytes = b; v.nframes = nf; v.frames = f;
      v.chk_k = k; v.exp_cnt = cnt; v.exp_full = full; v.exp_ovf = ovf;
      return v;
   endfunction

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check1({tag, "_tx"}, tx, 1'b1);
      check1({tag, "_busy"}, tx_busy, 1'b0);
      check8({tag, "_count"}, 8'(fifo_count), 8'd0);
      check1({tag, "_empty"}, fifo_empty, 1'b1);
      check1({tag, "_full"}, fifo_full, 1'b0);
      check1({tag, "_ovf"}, overflow, 1'b0);
   endtask

   // First write lands on edge N; tx is sampled after every edge from N+1 onward.
   task automatic run_vec(input vec_t v, input int idx);
      logic [9:0] cur;
      @(negedge clock);
      write_enable = 1'b1;
      write_data   = v.bytes[7:0];
      @(posedge clock);
      @(negedge clock);
      check8($sformatf("v%0d_count_after_N", idx), 8'(fifo_count), 8'd1);
      check1($sformatf("v%0d_idle_after_N", idx), tx_busy, 1'b0);
      for (int k = 0; k < v.nframes * 10 * CPB; k++) begin
         if (k + 1 < v.nwr) begin
            write_enable = 1'b1;
            write_data   = v.bytes[8*(k+1) +: 8];
         end else begin
            write_enable = 1'b0;
         end
         @(posedge clock);
         @(negedge clock);
         cur = v.frames[10*(k/(10*CPB)) +: 10];
         check1($sformatf("v%0d_tx_k%0d", idx, k), tx, cur[9 - (k % (10*CPB)) / CPB]);
         check1($sformatf("v%0d_busy_k%0d", idx, k), tx_busy, 1'b1);
         if (k == v.chk_k) begin
            check8($sformatf("v%0d_count_k%0d", idx, k), 8'(fifo_count), v.exp_cnt);
            check1($sformatf("v%0d_full_k%0d", idx, k), fifo_full, v.exp_full);
            check1($sformatf("v%0d_ovf_k%0d", idx, k), overflow, v.exp_ovf);
         end
      end
      write_enable = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check1($sformatf("v%0d_busy_end", idx), tx_busy, 1'b0);
      check1($sformatf("v%0d_tx_end", idx), tx, 1'b1);
      check8($sformatf("v%0d_count_end", idx), 8'(fifo_count), 8'd0);
      check1($sformatf("v%0d_ovf_end", idx), overflow, v.exp_ovf);
   endtask

   initial begin
      vecs[0] = mkv(1, 48'h55, 1, 60'(10'b0101010101), 0, 8'd0, 1'b0, 1'b0);
      vecs[1] = mkv(2, 48'h0FA3, 2, 60'({10'b0111100001, 10'b0110001011}), 0, 8'd1, 1'b0, 1'b0);
      vecs[2] = mkv(1, 48'h00, 1, 60'(10'b0000000001), 0, 8'd0, 1'b0, 1'b0);
      vecs[3] = mkv(1, 48'hFF, 1, 60'(10'b0111111111), 0, 8'd0, 1'b0, 1'b0);
      vecs[4] = mkv(1, 48'h80, 1, 60'(10'b0000000011), 0, 8'd0, 1'b0, 1'b0);
      vecs[5] = mkv(6, 48'h665544332211, 5,
                    60'({10'b0101010101, 10'b0001000101, 10'b0110011001,
                         10'b0010001001, 10'b0100010001}),
                    4, 8'd4, 1'b1, 1'b1);

      // Power-on reset.
      repeat (3) @(posedge clock);
      #1;
      check_reset_state("por");
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check_reset_state("post_release");

      foreach (vecs[i]) begin
         run_vec(vecs[i], i);
         repeat (2) @(negedge clock);
      end

      // Clear alone drops the sticky flag left by the overflowing burst.
      @(negedge clock);
      clear_overflow = 1'b1;
      @(negedge clock);
      clear_overflow = 1'b0;
      check1("clr_alone_1", overflow, 1'b0);

      // Fill: one byte goes straight to the shifter, four more fill the FIFO.
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         write_enable = 1'b1;
         write_data   = 8'hC0 + 8'(i);
      end
      @(negedge clock);
      check1("fill_full", fifo_full, 1'b1);
      check8("fill_count", 8'(fifo_count), 8'd4);
      check1("fill_ovf", overflow, 1'b0);
      write_enable   = 1'b1;
      write_data     = 8'hEE;
      clear_overflow = 1'b1;
      @(negedge clock);
      write_enable   = 1'b0;
      clear_overflow = 1'b0;
      check1("set_beats_clear", overflow, 1'b1);
      check8("dropped_count", 8'(fifo_count), 8'd4);
      clear_overflow = 1'b1;
      @(negedge clock);
      clear_overflow = 1'b0;
      check1("clr_alone_2", overflow, 1'b0);
      check1("busy_before_rst", tx_busy, 1'b1);

      // Mid-run reset while a frame is in flight and the FIFO holds data.
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_reset_state("midrun");
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_reset_state("midrun_rel");

      // Reset during data bit 3 of 0xFF with two bytes queued.
      write_enable = 1'b1;
      write_data   = 8'hFF;
      @(negedge clock);
      write_data = 8'h01;
      @(negedge clock);
      write_data = 8'h02;
      @(negedge clock);
      write_enable = 1'b0;
      // Now just after edge N+2; bit 3 is on the line after edges N+17..N+20.
      repeat (16) @(negedge clock);
      check8("s6_queued", 8'(fifo_count), 8'd2);
      check1("s6_busy", tx_busy, 1'b1);
      check1("s6_bit3", tx, 1'b1);
      reset = 1'b0;
      #1;
      check_reset_state("s6_rst");
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         check1($sformatf("s6_quiet_tx_%0d", k), tx, 1'b1);
         check1($sformatf("s6_quiet_busy_%0d", k), tx_busy, 1'b0);
      end
      check8("s6_count_final", 8'(fifo_count), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
